// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding,
// default address width, retired-instruction counter width and a
// saturating-increment helper.
package pc_sequencer_pkg;

   // Default PC / instruction address width.
   localparam int PC_ADDR_W = 16;

   // Width of the retired-instruction counter.
   localparam int CNT_W = 16;

   // Sequencer states (3-bit encoding).
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_FETCH  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_EXEC   = 3'd4,
      ST_HALTED = 3'd5
   } state_t;

   // Increment that sticks at all-ones instead of rolling over.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Instruction-sequencing FSM that drives an external PC register through
// pc_wr / pc_inc / pc_bin and handshakes with instruction memory.
//
// Every output is a register. Each state's action is captured at the clock
// edge that ends that state's cycle, so it is visible during the following
// cycle: the PC load/increment pulse appears during FETCH and the PC register
// has taken the new value by the time imem_req rises. imem_req stays high
// through WAIT and drops together with the fetch_valid pulse. halted tracks
// the HALTED state exactly (set on entry, cleared by start).
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int ADDR_W = PC_ADDR_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              imem_ready,
   input  logic              exec_done,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              stall,
   input  logic              halt_req,
   output logic              pc_wr,
   output logic              pc_inc,
   output logic [ADDR_W-1:0] pc_bin,
   output logic              imem_req,
   output logic              fetch_valid,
   output logic              pc_wrap,
   output logic [CNT_W-1:0]  instr_cnt,
   output logic              halted
);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_boot_addr;
   logic                r_halt_pend;
   logic                r_pc_wr;
   logic                r_pc_inc;
   logic [ADDR_W-1:0]   r_pc_bin;
   logic                r_imem_req;
   logic                r_fetch_valid;
   logic                r_pc_wrap;
   logic [CNT_W-1:0]    r_instr_cnt;
   logic                r_halted;

   logic                w_retire;
   logic                w_halt_now;
   logic                w_pc_max;

   // A retire needs exec_done while not stalled; stall masks exec_done.
   assign w_retire   = (r_state == ST_EXEC) && exec_done && !stall;
   assign w_halt_now = r_halt_pend || halt_req;
   assign w_pc_max   = (pc_in == {ADDR_W{1'b1}});

   // State transitions, halt latch, counter and registered output actions.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_boot_addr   <= '0;
         r_halt_pend   <= 1'b0;
         r_pc_wr       <= 1'b0;
         r_pc_inc      <= 1'b0;
         r_pc_bin      <= '0;
         r_imem_req    <= 1'b0;
         r_fetch_valid <= 1'b0;
         r_pc_wrap     <= 1'b0;
         r_instr_cnt   <= '0;
         r_halted      <= 1'b0;
      end else begin
         // Single-cycle actions default low; pc_bin is zero unless writing.
         r_pc_wr       <= 1'b0;
         r_pc_inc      <= 1'b0;
         r_pc_bin      <= '0;
         r_imem_req    <= 1'b0;
         r_fetch_valid <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state     <= ST_LOAD;
                  r_boot_addr <= start_addr;
                  r_pc_wrap   <= 1'b0;
                  r_halt_pend <= 1'b0;
               end
            end

            ST_LOAD: begin
               r_pc_wr  <= 1'b1;
               r_pc_bin <= r_boot_addr;
               r_state  <= ST_FETCH;
            end

            ST_FETCH: begin
               r_imem_req <= 1'b1;
               r_state    <= ST_WAIT;
               if (halt_req) begin
                  r_halt_pend <= 1'b1;
               end
            end

            ST_WAIT: begin
               if (halt_req) begin
                  r_halt_pend <= 1'b1;
               end
               if (imem_ready) begin
                  r_fetch_valid <= 1'b1;
                  r_state       <= ST_EXEC;
               end else begin
                  r_imem_req <= 1'b1;
               end
            end

            ST_EXEC: begin
               if (w_retire) begin
                  r_instr_cnt <= sat_inc(r_instr_cnt);
                  // A jump wins over the sequential increment.
                  if (jump_en) begin
                     r_pc_wr  <= 1'b1;
                     r_pc_bin <= jump_addr;
                  end else begin
                     r_pc_inc <= 1'b1;
                     if (w_pc_max) begin
                        r_pc_wrap <= 1'b1;
                     end
                  end
                  if (w_halt_now) begin
                     r_state  <= ST_HALTED;
                     r_halted <= 1'b1;
                  end else begin
                     r_state <= ST_FETCH;
                  end
               end else if (halt_req) begin
                  // Remember a halt request that arrives while stalled or waiting.
                  r_halt_pend <= 1'b1;
               end
            end

            ST_HALTED: begin
               if (start) begin
                  r_state     <= ST_LOAD;
                  r_boot_addr <= start_addr;
                  r_halted    <= 1'b0;
                  r_halt_pend <= 1'b0;
                  r_pc_wrap   <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign pc_wr       = r_pc_wr;
   assign pc_inc      = r_pc_inc;
   assign pc_bin      = r_pc_bin;
   assign imem_req    = r_imem_req;
   assign fetch_valid = r_fetch_valid;
   assign pc_wrap     = r_pc_wrap;
   assign instr_cnt   = r_instr_cnt;
   assign halted      = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: models the external PC register, queues the
// expected PC-write / PC-increment / fetch_valid events and compares them
// as the DUT emits them, plus inline per-scenario checks.
module tb_pc_sequencer;

   localparam int AW = 16;
   localparam logic [2:0] EV_WR  = 3'b001;
   localparam logic [2:0] EV_INC = 3'b010;
   localparam logic [2:0] EV_FV  = 3'b100;

   typedef struct {
      logic [2:0]    code;
      logic [AW-1:0] bin;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW-1:0] pc_in;
   logic          imem_ready = 1'b0;
   logic          exec_done = 1'b0;
   logic          jump_en = 1'b0;
   logic [AW-1:0] jump_addr = '0;
   logic          stall = 1'b0;
   logic          halt_req = 1'b0;
   logic          pc_wr;
   logic          pc_inc;
   logic [AW-1:0] pc_bin;
   logic          imem_req;
   logic          fetch_valid;
   logic          pc_wrap;
   logic [15:0]   instr_cnt;
   logic          halted;

   logic [AW-1:0] tb_pc = '0;
   ev_t           exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            exp_cnt = 0;

   pc_sequencer #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .pc_in(pc_in), .imem_ready(imem_ready), .exec_done(exec_done),
      .jump_en(jump_en), .jump_addr(jump_addr), .stall(stall),
      .halt_req(halt_req), .pc_wr(pc_wr), .pc_inc(pc_inc), .pc_bin(pc_bin),
      .imem_req(imem_req), .fetch_valid(fetch_valid), .pc_wrap(pc_wrap),
      .instr_cnt(instr_cnt), .halted(halted)
   );

   always #5 clk = ~clk;

   // External PC register driven by the sequencer.
   always @(posedge clk) begin
      if (pc_wr === 1'b1)       tb_pc <= pc_bin;
      else if (pc_inc === 1'b1) tb_pc <= tb_pc + 16'd1;
   end
   assign pc_in = tb_pc;

   // Scoreboard: every PC action or fetch pulse must match the next queued event.
   always @(negedge clk) begin
      if (pc_wr === 1'b1 || pc_inc === 1'b1 || fetch_valid === 1'b1) begin
         ev_t e;
         logic [2:0] obs;
         obs = {fetch_valid, pc_inc, pc_wr};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got code=%b bin=%h, required none", obs, pc_bin);
         end else begin
            e = exp_q.pop_front();
            if (obs !== e.code || pc_bin !== ((e.code == EV_WR) ? e.bin : 16'h0000)) begin
               errors++;
               $display("FAIL event: got code=%b bin=%h, required code=%b bin=%h",
                        obs, pc_bin, e.code, (e.code == EV_WR) ? e.bin : 16'h0000);
            end else begin
               $display("event code=%b bin=%h ok", obs, pc_bin);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // From a WAIT cycle: n more WAIT cycles, then memory answers; ends in EXEC.
   task automatic wait_to_exec(input int n);
      repeat (n) step();
      imem_ready = 1'b1;
      exp_q.push_back('{EV_FV, 16'h0000});
      step();
      imem_ready = 1'b0;
   endtask

   // From EXEC: retire one instruction; ends in the cycle showing the PC action.
   task automatic retire(input logic jmp, input logic [AW-1:0] addr);
      exec_done = 1'b1;
      jump_en   = jmp;
      jump_addr = addr;
      if (jmp) exp_q.push_back('{EV_WR, addr});
      else     exp_q.push_back('{EV_INC, 16'h0000});
      exp_cnt++;
      step();
      exec_done = 1'b0;
      jump_en   = 1'b0;
      jump_addr = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if ({pc_wr, pc_inc, imem_req, fetch_valid, pc_wrap, halted} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b, required 000000",
                  {pc_wr, pc_inc, imem_req, fetch_valid, pc_wrap, halted});
      end
      checks++;
      if (pc_bin !== 16'h0000 || instr_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL reset_values: got bin=%h cnt=%h, required 0000 0000", pc_bin, instr_cnt);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_boot();
      start = 1'b1;
      start_addr = 16'h00FF;
      step();
      start = 1'b0;
      exp_q.push_back('{EV_WR, 16'h00FF});
      step();
      checks++;
      if (pc_wr !== 1'b1 || pc_bin !== 16'h00FF || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL boot_load: got wr=%b bin=%h req=%b, required 1 00ff 0", pc_wr, pc_bin, imem_req);
      end
      step();
      checks++;
      if (imem_req !== 1'b1 || pc_wr !== 1'b0 || pc_bin !== 16'h0000 || tb_pc !== 16'h00FF) begin
         errors++;
         $display("FAIL boot_fetch: got req=%b wr=%b bin=%h pc=%h, required 1 0 0000 00ff",
                  imem_req, pc_wr, pc_bin, tb_pc);
      end
   endtask

   task automatic test_sequential();
      step();
      checks++;
      if (imem_req !== 1'b1) begin
         errors++;
         $display("FAIL wait_hold_req: got %b, required 1", imem_req);
      end
      wait_to_exec(0);
      checks++;
      if (fetch_valid !== 1'b1 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL fetch_valid: got fv=%b req=%b, required 1 0", fetch_valid, imem_req);
      end
      retire(1'b0, '0);
      checks++;
      if (pc_inc !== 1'b1 || pc_wr !== 1'b0 || fetch_valid !== 1'b0) begin
         errors++;
         $display("FAIL seq_inc: got inc=%b wr=%b fv=%b, required 1 0 0", pc_inc, pc_wr, fetch_valid);
      end
      step();
      checks++;
      if (tb_pc !== 16'h0100 || instr_cnt !== 16'd1 || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL seq_result: got pc=%h cnt=%0d req=%b, required 0100 1 1", tb_pc, instr_cnt, imem_req);
      end
   endtask

   task automatic test_jump();
      wait_to_exec(0);
      retire(1'b1, 16'h00CC);
      checks++;
      if (pc_wr !== 1'b1 || pc_bin !== 16'h00CC || pc_inc !== 1'b0) begin
         errors++;
         $display("FAIL jump_action: got wr=%b bin=%h inc=%b, required 1 00cc 0", pc_wr, pc_bin, pc_inc);
      end
      step();
      checks++;
      if (imem_req !== 1'b1 || tb_pc !== 16'h00CC || instr_cnt !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL jump_result: got req=%b pc=%h cnt=%0d, required 1 00cc %0d",
                  imem_req, tb_pc, instr_cnt, exp_cnt);
      end
   endtask

   task automatic test_wrap();
      wait_to_exec(1);
      retire(1'b1, 16'hFFFF);
      step();
      checks++;
      if (tb_pc !== 16'hFFFF || pc_wrap !== 1'b0) begin
         errors++;
         $display("FAIL pre_wrap: got pc=%h wrap=%b, required ffff 0", tb_pc, pc_wrap);
      end
      wait_to_exec(0);
      retire(1'b0, '0);
      checks++;
      if (pc_inc !== 1'b1 || pc_wrap !== 1'b1) begin
         errors++;
         $display("FAIL wrap_set: got inc=%b wrap=%b, required 1 1", pc_inc, pc_wrap);
      end
      step();
      checks++;
      if (tb_pc !== 16'h0000 || pc_wrap !== 1'b1) begin
         errors++;
         $display("FAIL wrap_pc: got pc=%h wrap=%b, required 0000 1", tb_pc, pc_wrap);
      end
      wait_to_exec(2);
      retire(1'b0, '0);
      step();
      checks++;
      if (tb_pc !== 16'h0001 || pc_wrap !== 1'b1 || instr_cnt !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL wrap_sticky: got pc=%h wrap=%b cnt=%0d, required 0001 1 %0d",
                  tb_pc, pc_wrap, instr_cnt, exp_cnt);
      end
   endtask

   task automatic test_stall_halt();
      logic [AW-1:0] held_pc;
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      wait_to_exec(0);
      stall = 1'b1;
      exec_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (pc_wr !== 1'b0 || pc_inc !== 1'b0 || instr_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL stall_%0d: got wr=%b inc=%b cnt=%0d, required 0 0 %0d",
                     i, pc_wr, pc_inc, instr_cnt, exp_cnt);
         end
      end
      stall = 1'b0;
      retire(1'b0, '0);
      checks++;
      if (pc_inc !== 1'b1 || halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_retire: got inc=%b halted=%b, required 1 1", pc_inc, halted);
      end
      step();
      held_pc = tb_pc;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (imem_req !== 1'b0 || halted !== 1'b1 || tb_pc !== held_pc) begin
            errors++;
            $display("FAIL halted_%0d: got req=%b halted=%b pc=%h, required 0 1 %h",
                     i, imem_req, halted, tb_pc, held_pc);
         end
      end
   endtask

   task automatic test_restart();
      start = 1'b1;
      start_addr = 16'h1234;
      step();
      start = 1'b0;
      checks++;
      if (halted !== 1'b0 || pc_wrap !== 1'b0) begin
         errors++;
         $display("FAIL restart_clear: got halted=%b wrap=%b, required 0 0", halted, pc_wrap);
      end
      exp_q.push_back('{EV_WR, 16'h1234});
      step();
      step();
      checks++;
      if (tb_pc !== 16'h1234 || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL restart_fetch: got pc=%h req=%b, required 1234 1", tb_pc, imem_req);
      end
   endtask

   task automatic test_start_ignored();
      start = 1'b1;
      start_addr = 16'hAAAA;
      step();
      start = 1'b0;
      checks++;
      if (pc_wr !== 1'b0 || imem_req !== 1'b1 || halted !== 1'b0) begin
         errors++;
         $display("FAIL start_ignored: got wr=%b req=%b halted=%b, required 0 1 0", pc_wr, imem_req, halted);
      end
   endtask

   task automatic test_reset_wait();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if ({pc_wr, pc_inc, imem_req, fetch_valid, pc_wrap, halted} !== 6'b0 ||
          pc_bin !== 16'h0000 || instr_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL reset_in_wait: got flags=%b bin=%h cnt=%h, required 000000 0000 0000",
                  {pc_wr, pc_inc, imem_req, fetch_valid, pc_wrap, halted}, pc_bin, instr_cnt);
      end
      imem_ready = 1'b1;
      exec_done = 1'b1;
      step();
      step();
      checks++;
      if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || pc_wr !== 1'b0 || pc_inc !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got req=%b fv=%b wr=%b inc=%b, required 0 0 0 0",
                  imem_req, fetch_valid, pc_wr, pc_inc);
      end
      imem_ready = 1'b0;
      exec_done = 1'b0;
   endtask

   task automatic test_drained();
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending events, required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_boot();
      test_sequential();
      test_jump();
      test_wrap();
      test_stall_halt();
      test_restart();
      test_start_ignored();
      test_reset_wait();
      test_drained();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
